// File: rtl/axi_rd.sv
// Purpose: frame-buffer read master; walks a 2-D frame in FDMA bursts into a show-ahead FIFO for the user side.
// Latency: an FDMA word accepted at a clock edge shows on O_R_data (O_R_empty=0) right after that edge.
// Backpressure: a burst is requested only when the FIFO can take all of it; O_R_ovf flags forced overflow. Macro AXI_RD_IRQ_EN adds the frame-done irq.

module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_wr_vld,
    input  logic [W-1:0]             i_wr_dat,
    input  logic                     i_rd_rdy,
    output logic [W-1:0]             o_rd_dat,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_cnt,
    output logic                     o_ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          r_ovf;
    logic          w_full;
    logic          w_wr;
    logic          w_rd;

    assign w_full   = (r_cnt == (AW+1)'(DEPTH));
    assign w_wr     = i_wr_vld && !w_full;
    assign w_rd     = i_rd_rdy && (r_cnt != '0);
    assign o_rd_dat = r_mem[r_rptr];
    assign o_empty  = (r_cnt == '0);
    assign o_cnt    = r_cnt;
    assign o_ovf    = r_ovf;

    // storage array, written only when there is room
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wptr] <= i_wr_dat;
    end

    // pointers and occupancy; flush empties without touching the sticky overflow flag
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + AW'(1);
            if (w_rd) r_rptr <= r_rptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // overflow stays set until reset
    always_ff @(posedge i_clk) begin
        if (i_rst)                  r_ovf <= 1'b0;
        else if (i_wr_vld && w_full) r_ovf <= 1'b1;
    end
endmodule

module axi_rd #(
    parameter int                        AXI_DATA_WIDTH = 128,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] R_BASEADDR     = '0,
    parameter int                        R_DSIZEBITS    = 24,
    parameter int                        R_XSIZE        = 1920,
    parameter int                        R_XSTRIDE      = 1920,
    parameter int                        R_YSIZE        = 1080,
    parameter int                        R_XDIV         = 2,
    parameter int                        R_BUFSIZE      = 3,
    parameter int                        R_FIFO_DEPTH   = 512
) (
    input  logic                      I_ui_clk,
    input  logic                      I_ui_rst,
    input  logic                      I_R_FS,
    input  logic                      I_R_rden,
    output logic [AXI_DATA_WIDTH-1:0] O_R_data,
    output logic                      O_R_empty,
    output logic                      O_R_ovf,
    input  logic [7:0]                I_R_buf,
    output logic [7:0]                O_R_sync_cnt,
    output logic [AXI_ADDR_WIDTH-1:0] O_fdma_raddr,
    output logic                      O_fdma_rareq,
    output logic [15:0]               O_fdma_rsize,
    input  logic                      I_fdma_rbusy,
    input  logic                      I_fdma_rvalid,
    input  logic [AXI_DATA_WIDTH-1:0] I_fdma_rdata,
    output logic                      O_fdma_rready,
    output logic [7:0]                O_fmda_rbuf,
    output logic                      O_fdma_rirq
);
    localparam int BURST  = R_XSIZE / R_XDIV;
    localparam int BINC   = BURST * AXI_DATA_WIDTH / 8;
    localparam int LINC   = (R_XSTRIDE - R_XSIZE) * AXI_DATA_WIDTH / 8 + BINC;
    localparam int NBURST = R_YSIZE * R_XDIV;
    localparam int AW     = $clog2(R_FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_WAIT = 3'd2,
        S_REQ  = 3'd3,
        S_DATA = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [R_DSIZEBITS-1:0] r_addr;
    logic [15:0]            r_bcnt;
    logic [7:0]             r_divcnt;
    logic [7:0]             r_bufn;
    logic [7:0]             r_sync_cnt;
    logic [7:0]             r_rbuf;
    logic [2:0]             r_rst_cnt;
    logic                   w_rareq;
    logic                   w_rready;
    logic                   w_flush;
    logic                   w_last;
    logic                   w_done;
    logic [AW:0]            w_fcnt;
    logic [AW:0]            w_free;

    assign w_last = (r_bcnt == 16'(NBURST - 1));
    assign w_done = (r_state == S_DATA) && !I_fdma_rbusy && w_last;
    assign w_free = (AW+1)'(R_FIFO_DEPTH) - w_fcnt;

    sync_fifo #(
        .W     (AXI_DATA_WIDTH),
        .DEPTH (R_FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (I_ui_clk),
        .i_rst    (I_ui_rst),
        .i_flush  (w_flush),
        .i_wr_vld (I_fdma_rvalid && w_rready),
        .i_wr_dat (I_fdma_rdata),
        .i_rd_rdy (I_R_rden),
        .o_rd_dat (O_R_data),
        .o_empty  (O_R_empty),
        .o_cnt    (w_fcnt),
        .o_ovf    (O_R_ovf)
    );

`ifdef AXI_RD_IRQ_EN
    logic [5:0] r_irq_cnt;

    // frame-done pulse stretched to 60 cycles
    always_ff @(posedge I_ui_clk) begin
        if (I_ui_rst)               r_irq_cnt <= '0;
        else if (w_done)            r_irq_cnt <= 6'd60;
        else if (r_irq_cnt != '0)   r_irq_cnt <= r_irq_cnt - 6'd1;
    end
    assign O_fdma_rirq = (r_irq_cnt != '0);
`else
    assign O_fdma_rirq = 1'b0;
`endif

    // state register
    always_ff @(posedge I_ui_clk) begin
        if (I_ui_rst) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_rareq     = 1'b0;
        w_rready    = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            S_IDLE: if (I_R_FS) w_state_nxt = S_RST;
            S_RST: begin
                w_flush = 1'b1;
                if (r_rst_cnt == 3'd7 && !O_fdma_rirq) w_state_nxt = S_WAIT;
            end
            S_WAIT: if (w_free >= (AW+1)'(BURST)) w_state_nxt = S_REQ;
            S_REQ: begin
                w_rareq = !I_fdma_rbusy;
                if (I_fdma_rbusy) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                w_rready = 1'b1;
                if (!I_fdma_rbusy) w_state_nxt = w_last ? S_IDLE : S_WAIT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // frame walk: buffer latch, burst/line addressing, frame counters
    always_ff @(posedge I_ui_clk) begin
        if (I_ui_rst) begin
            r_addr     <= '0;
            r_bcnt     <= '0;
            r_divcnt   <= '0;
            r_bufn     <= '0;
            r_sync_cnt <= '0;
            r_rbuf     <= '0;
            r_rst_cnt  <= '0;
        end else begin
            r_rst_cnt <= '0;
            case (r_state)
                S_IDLE: begin
                    r_addr   <= '0;
                    r_bcnt   <= '0;
                    r_divcnt <= '0;
                    if (I_R_FS)
                        r_sync_cnt <= (r_sync_cnt == 8'(R_BUFSIZE - 1)) ? 8'd0 : r_sync_cnt + 8'd1;
                end
                S_RST: begin
                    if (r_rst_cnt == 3'd0) r_bufn <= I_R_buf;
                    r_rst_cnt <= (r_rst_cnt == 3'd7) ? r_rst_cnt : r_rst_cnt + 3'd1;
                end
                S_DATA: begin
                    if (!I_fdma_rbusy) begin
                        if (w_last) begin
                            r_rbuf <= r_bufn;
                        end else begin
                            r_bcnt <= r_bcnt + 16'd1;
                            if (r_divcnt < 8'(R_XDIV - 1)) begin
                                r_addr   <= r_addr + R_DSIZEBITS'(BINC);
                                r_divcnt <= r_divcnt + 8'd1;
                            end else begin
                                r_addr   <= r_addr + R_DSIZEBITS'(LINC);
                                r_divcnt <= '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign O_fdma_rareq  = w_rareq;
    assign O_fdma_rready = w_rready;
    assign O_fdma_rsize  = 16'(BURST);
    assign O_fdma_raddr  = R_BASEADDR + AXI_ADDR_WIDTH'({r_bufn, r_addr});
    assign O_R_sync_cnt  = r_sync_cnt;
    assign O_fmda_rbuf   = r_rbuf;
endmodule

// File: tb/tb_axi_rd.sv
// Directed bench for axi_rd: small frame (8x4 words, 2 bursts per line), 16-deep FIFO.
// The FDMA side is played by tasks in the main sequence; expected addresses and data are hand-computed.
`timescale 1ns/1ps
module tb_axi_rd;
    logic        clk = 1'b0;
    logic        rst;
    logic        fs;
    logic        rden;
    logic [7:0]  rbuf_in;
    logic        busy;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] o_rdata;
    logic        o_empty;
    logic        o_ovf;
    logic [7:0]  o_sync;
    logic [31:0] o_raddr;
    logic        o_rareq;
    logic [15:0] o_rsize;
    logic        o_rready;
    logic [7:0]  o_rbuf;
    logic        o_rirq;

    axi_rd #(
        .AXI_DATA_WIDTH (32),
        .AXI_ADDR_WIDTH (32),
        .R_BASEADDR     (32'h1000),
        .R_DSIZEBITS    (12),
        .R_XSIZE        (8),
        .R_XSTRIDE      (16),
        .R_YSIZE        (4),
        .R_XDIV         (2),
        .R_BUFSIZE      (3),
        .R_FIFO_DEPTH   (16)
    ) dut (
        .I_ui_clk      (clk),
        .I_ui_rst      (rst),
        .I_R_FS        (fs),
        .I_R_rden      (rden),
        .O_R_data      (o_rdata),
        .O_R_empty     (o_empty),
        .O_R_ovf       (o_ovf),
        .I_R_buf       (rbuf_in),
        .O_R_sync_cnt  (o_sync),
        .O_fdma_raddr  (o_raddr),
        .O_fdma_rareq  (o_rareq),
        .O_fdma_rsize  (o_rsize),
        .I_fdma_rbusy  (busy),
        .I_fdma_rvalid (rvalid),
        .I_fdma_rdata  (rdata),
        .O_fdma_rready (o_rready),
        .O_fmda_rbuf   (o_rbuf),
        .O_fdma_rirq   (o_rirq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int wr_word = 1;
    int rd_word = 1;
    int offs [8] = '{32'h00, 32'h10, 32'h40, 32'h50, 32'h80, 32'h90, 32'hC0, 32'hD0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // act as FDMA for one burst: wait for the request, go busy, stream words, drop busy
    task automatic serve(input int nw, output logic [31:0] addr);
        int t = 0;
        while (!o_rareq && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("rareq_seen", 64'(o_rareq), 64'd1);
        addr = o_raddr;
        busy = 1'b1;
        @(negedge clk);
        chk("rready_in_data", 64'(o_rready), 64'd1);
        for (int k = 0; k < nw; k++) begin
            rvalid = 1'b1;
            rdata  = 32'(wr_word);
            wr_word++;
            @(negedge clk);
        end
        rvalid = 1'b0;
        busy   = 1'b0;
        @(negedge clk);
    endtask

    // user-side reads with show-ahead data checked before each consuming edge
    task automatic rd(input int n);
        for (int k = 0; k < n; k++) begin
            chk("rd_not_empty", 64'(o_empty), 64'd0);
            chk("rd_data", 64'(o_rdata), 64'(rd_word));
            rd_word++;
            rden = 1'b1;
            @(negedge clk);
            rden = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [31:0] base);
        logic [31:0] a;
        for (int b = 0; b < 8; b++) begin
            serve(4, a);
            chk("frame_addr", 64'(a), 64'(base + 32'(offs[b])));
            rd(4);
        end
    endtask

    task automatic fs_pulse();
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int  hi;
        bit  held;
        int  exp_hi;

        rst = 1'b1; fs = 1'b0; rden = 1'b0; rbuf_in = 8'd0;
        busy = 1'b0; rvalid = 1'b0; rdata = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_state",  64'(dut.r_state), 64'd0);
        chk("rst_empty",  64'(o_empty),  64'd1);
        chk("rst_ovf",    64'(o_ovf),    64'd0);
        chk("rst_rareq",  64'(o_rareq),  64'd0);
        chk("rst_rready", 64'(o_rready), 64'd0);
        chk("rst_sync",   64'(o_sync),   64'd0);
        chk("rst_rbuf",   64'(o_rbuf),   64'd0);
        chk("rst_irq",    64'(o_rirq),   64'd0);
        chk("rsize",      64'(o_rsize),  64'd4);

        // read strobe on an empty FIFO is ignored
        rst = 1'b0;
        rden = 1'b1;
        @(negedge clk);
        rden = 1'b0;
        chk("empty_rd_cnt",   64'(dut.w_fcnt), 64'd0);
        chk("empty_rd_empty", 64'(o_empty),    64'd1);

        // frame start on buffer 1; a second FS while busy is ignored
        rbuf_in = 8'd1;
        fs_pulse();
        chk("fs1_sync",  64'(o_sync), 64'd1);
        chk("fs1_state", 64'(dut.r_state), 64'd1);
        fs_pulse();
        chk("fs_ignored", 64'(o_sync), 64'd1);

        // first four bursts, no user reads
        serve(4, a); chk("addr0", 64'(a), 64'h2000);
        chk("fwft_empty", 64'(o_empty), 64'd0);
        chk("fwft_head",  64'(o_rdata), 64'd1);
        serve(4, a); chk("addr1", 64'(a), 64'h2010);
        serve(4, a); chk("addr2", 64'(a), 64'h2040);
        serve(4, a); chk("addr3", 64'(a), 64'h2050);
        repeat (5) @(negedge clk);
        chk("full_state", 64'(dut.r_state), 64'd2);
        chk("full_cnt",   64'(dut.w_fcnt),  64'd16);
        chk("full_noreq", 64'(o_rareq),     64'd0);

        // four reads free room for the fifth burst; one extra forced word overflows
        rd(4);
        serve(5, a); chk("addr4", 64'(a), 64'h2080);
        chk("ovf_set", 64'(o_ovf),       64'd1);
        chk("ovf_cnt", 64'(dut.w_fcnt),  64'd16);
        rd(16);
        chk("drained", 64'(o_empty), 64'd1);
        rd_word = wr_word;

        serve(4, a); chk("addr5", 64'(a), 64'h2090); rd(4);
        serve(4, a); chk("addr6", 64'(a), 64'h20C0); rd(4);
        serve(4, a); chk("addr7", 64'(a), 64'h20D0);

        // frame done: irq window, FS during irq holds in S_RST
        chk("done_state", 64'(dut.r_state), 64'd0);
        chk("done_rbuf",  64'(o_rbuf), 64'd1);
`ifdef AXI_RD_IRQ_EN
        exp_hi = 60;
`else
        exp_hi = 0;
`endif
        hi = 0;
        held = 1'b1;
        fs = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (o_rirq) hi++;
            @(negedge clk);
            fs = 1'b0;
            if (o_rirq && dut.r_state != 3'd1) held = 1'b0;
        end
        chk("irq_cycles", 64'(hi),   64'(exp_hi));
        chk("rst_held",   64'(held), 64'd1);
        chk("fs2_sync",   64'(o_sync), 64'd2);
        chk("flushed",    64'(o_empty), 64'd1);
        chk("req_after",  64'(dut.r_state), 64'd3);
        chk("req_addr",   64'(o_raddr), 64'h2000);
        rd_word = wr_word;

        // reset mid-burst after two words; later data is discarded
        busy = 1'b1;
        @(negedge clk);
        rvalid = 1'b1; rdata = 32'hDEAD0001;
        @(negedge clk);
        rdata = 32'hDEAD0002;
        @(negedge clk);
        chk("mid_cnt", 64'(dut.w_fcnt), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_state",  64'(dut.r_state), 64'd0);
        chk("mid_rst_empty",  64'(o_empty),  64'd1);
        chk("mid_rst_rready", 64'(o_rready), 64'd0);
        chk("mid_rst_ovf",    64'(o_ovf),    64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_drop", 64'(o_empty), 64'd1);
        rvalid = 1'b0;
        busy   = 1'b0;
        @(negedge clk);

        // three full frames: sync counter 1, 2, 0 and buffer selection
        rbuf_in = 8'd1; fs_pulse();
        chk("f1_sync", 64'(o_sync), 64'd1);
        run_frame(32'h2000);
        chk("f1_rbuf", 64'(o_rbuf), 64'd1);
        rbuf_in = 8'd2; fs_pulse();
        chk("f2_sync", 64'(o_sync), 64'd2);
        run_frame(32'h3000);
        chk("f2_rbuf", 64'(o_rbuf), 64'd2);
        rbuf_in = 8'd0; fs_pulse();
        chk("f3_sync", 64'(o_sync), 64'd0);
        run_frame(32'h1000);
        chk("f3_rbuf", 64'(o_rbuf), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
